dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 30 +++
 rtl/dmem_array.sv | 34 +++
 rtl/dmem_ctrl.sv | 147 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-addressed data memory controller.
// Latency: n/a (types, constants and one helper only).
// Backpressure: n/a.
package dmem_pkg;

    localparam int MAX_LATENCY = 8;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        int unsigned n;
        case (size_e'(sz))
            SIZE_B:  n = 1;
            SIZE_H:  n = 2;
            SIZE_W:  n = 4;
            default: n = 8;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Byte array with per-lane write enables; lane l maps to byte (base + l) mod DEPTH.
// Latency: combinational read, write commits on the rising edge.
// Backpressure: none; always ready. Contents are deliberately not reset.
module dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 1024
) (
    input  logic                       clk_i,
    input  logic [$clog2(DEPTH)-1:0]   base_i,
    input  logic [DATA_W/8-1:0]        be_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          rdata_o
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic [7:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        for (int l = 0; l < NB; l++) begin
            if (be_i[l]) begin
                mem_q[base_i + IDX_W'(l)] <= wdata_i[8*l +: 8];
            end
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int l = 0; l < NB; l++) begin
            rdata_o[8*l +: 8] = mem_q[base_i + IDX_W'(l)];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-outstanding data memory controller: write commit / read sample at accept, response after LATENCY cycles.
// Latency: LATENCY cycles from accept to resp_valid_o; fault detection compiled in with DMEM_ERR_CHECK_EN.
// Backpressure: response held stable until resp_ready_i; req_ready_o only in IDLE, never on the handshake cycle.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [1:0]        req_size_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_error_o
);
    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(MAX_LATENCY);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              error_q, error_d;

    int unsigned       nb_c;
    logic [NB-1:0]     lane_en_c;
    logic [NB-1:0]     wr_be_c;
    logic              fault_c;
    logic              accept_c;
    logic [DATA_W-1:0] arr_rdata;
    logic [DATA_W-1:0] rd_masked_c;

    // Access size is capped at the bus width; lanes above it are never touched.
    always_comb begin
        nb_c = size_bytes(req_size_i);
        if (nb_c > NB) begin
            nb_c = NB;
        end
        lane_en_c = '0;
        for (int l = 0; l < NB; l++) begin
            lane_en_c[l] = (l < nb_c);
        end
    end

`ifdef DMEM_ERR_CHECK_EN
    logic [ADDR_W:0] last_c;
    logic            oob_c;
    logic            mis_c;

    // The extra top bit of last_c catches wrap past 2^ADDR_W as out of range.
    always_comb begin
        last_c  = {1'b0, req_addr_i} + (ADDR_W+1)'(nb_c) - (ADDR_W+1)'(1);
        oob_c   = last_c > (ADDR_W+1)'(DEPTH - 1);
        mis_c   = (req_addr_i & ADDR_W'(nb_c - 1)) != '0;
        fault_c = oob_c | mis_c;
    end
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[ADDR_W-1:IDX_W];
    assign fault_c        = 1'b0;
`endif

    assign accept_c = (state_q == ST_IDLE) && req_valid_i;
    assign wr_be_c  = (accept_c && req_we_i && !fault_c) ? lane_en_c : '0;

    always_comb begin
        rd_masked_c = '0;
        for (int l = 0; l < NB; l++) begin
            if (lane_en_c[l] && !req_we_i && !fault_c) begin
                rd_masked_c[8*l +: 8] = arr_rdata[8*l +: 8];
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk_i   (clk_i),
        .base_i  (req_addr_i[IDX_W-1:0]),
        .be_i    (wr_be_c),
        .wdata_i (req_wdata_i),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    rdata_d = rd_masked_c;
                    error_d = fault_c;
                    if (LATENCY == 1) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_rdata_o = rdata_q;
    assign resp_error_o = error_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed plus randomized bench for dmem_ctrl against a byte-array reference model.
// Works with or without DMEM_ERR_CHECK_EN.
module tb_dmem_ctrl;
    localparam int DW    = 64;
    localparam int AW    = 64;
    localparam int DEPTH = 1024;
    localparam int LAT   = 3;

    logic          clk;
    logic          rst_n_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_we_i;
    logic [AW-1:0] req_addr_i;
    logic [1:0]    req_size_i;
    logic [DW-1:0] req_wdata_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [DW-1:0] resp_rdata_o;
    logic          resp_error_o;

    dmem_ctrl #(
        .DATA_W  (DW),
        .ADDR_W  (AW),
        .DEPTH   (DEPTH),
        .LATENCY (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_size_i   (req_size_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .resp_rdata_o (resp_rdata_o),
        .resp_error_o (resp_error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int nchk  = 0;
    int nfail = 0;

    logic [7:0] mem_m [DEPTH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (failure #%0d)", tag, obs, exp, nfail);
        end
    endtask

    // Reference: an access touches bytes addr..addr+n-1 (mod DEPTH when unchecked).
    task automatic model(input logic we, input logic [63:0] addr, input logic [1:0] size,
                         input logic [63:0] wdata, output logic [63:0] rdata, output logic err);
        int          nb;
        logic [64:0] last;
        logic [63:0] idx;
        nb = 1 << size;
        if (nb > DW / 8) nb = DW / 8;
        last = {1'b0, addr} + 65'(nb) - 65'd1;
        err  = 1'b0;
`ifdef DMEM_ERR_CHECK_EN
        err = (last >= 65'(DEPTH)) || ((addr % 64'(nb)) != 64'd0);
`endif
        rdata = '0;
        if (!err) begin
            for (int i = 0; i < nb; i++) begin
                idx = (addr + 64'(i)) % 64'(DEPTH);
                if (we) mem_m[idx] = wdata[8*i +: 8];
                else    rdata[8*i +: 8] = mem_m[idx];
            end
        end
    endtask

    task automatic txn(input logic we, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata, input int hold, input string tag,
                       output logic [63:0] rd, output logic er);
        logic [63:0] exp_d;
        logic        exp_e;
        int          cyc;
        chk({tag, ".rdy"}, 64'(req_ready_o), 64'd1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = addr;
        req_size_i  = size;
        req_wdata_i = wdata;
        model(we, addr, size, wdata, exp_d, exp_e);
        @(negedge clk);
        // Junk on the request bus while busy must be ignored.
        req_valid_i = 1'($urandom_range(0, 1));
        req_we_i    = 1'($urandom_range(0, 1));
        req_addr_i  = 64'($urandom_range(0, DEPTH - 1));
        req_size_i  = 2'($urandom_range(0, 3));
        req_wdata_i = {$urandom, $urandom};
        cyc = 1;
        while (!resp_valid_o && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, ".lat"},   64'(cyc), 64'(LAT));
        chk({tag, ".rdata"}, resp_rdata_o, exp_d);
        chk({tag, ".err"},   64'(resp_error_o), 64'(exp_e));
        chk({tag, ".busy"},  64'(req_ready_o), 64'd0);
        resp_ready_i = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, ".hold_vld"},   64'(resp_valid_o), 64'd1);
            chk({tag, ".hold_rdata"}, resp_rdata_o, exp_d);
            chk({tag, ".hold_err"},   64'(resp_error_o), 64'(exp_e));
            chk({tag, ".hold_rdy"},   64'(req_ready_o), 64'd0);
        end
        rd = resp_rdata_o;
        er = resp_error_o;
        resp_ready_i = 1'b1;
        @(negedge clk);
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        chk({tag, ".done"}, {62'd0, resp_valid_o, req_ready_o}, 64'd1);
    endtask

    logic [63:0] rd;
    logic        er;
    logic [63:0] ra;

    initial begin
        rst_n_i      = 1'b0;
        req_valid_i  = 1'b0;
        req_we_i     = 1'b0;
        req_addr_i   = '0;
        req_size_i   = '0;
        req_wdata_i  = '0;
        resp_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.rdy",   64'(req_ready_o),  64'd1);
        chk("rst.vld",   64'(resp_valid_o), 64'd0);
        chk("rst.rdata", resp_rdata_o,      64'd0);
        chk("rst.err",   64'(resp_error_o), 64'd0);
        rst_n_i = 1'b1;
        @(negedge clk);

        for (int a = 0; a < DEPTH; a += 8)
            txn(1'b1, 64'(a), 2'd3, {$urandom, $urandom}, 0, "fill", rd, er);

        txn(1'b1, 64'h10, 2'd3, 64'h1122334455667788, 0, "wr_full", rd, er);
        chk("wr_full.rd0", rd, 64'd0);
        txn(1'b0, 64'h10, 2'd3, 64'd0, 0, "rd_full", rd, er);
        chk("rd_full.val", rd, 64'h1122334455667788);
        chk("rd_full.e0",  64'(er), 64'd0);
        txn(1'b0, 64'h12, 2'd1, 64'd0, 0, "rd_half", rd, er);
        chk("rd_half.val", rd, 64'h5566);
        txn(1'b0, 64'h11, 2'd1, 64'd0, 0, "rd_mis", rd, er);
`ifdef DMEM_ERR_CHECK_EN
        chk("rd_mis.err", 64'(er), 64'd1);
        chk("rd_mis.rd0", rd, 64'd0);
`else
        chk("rd_mis.err", 64'(er), 64'd0);
        chk("rd_mis.val", rd, 64'h6677);
`endif

        txn(1'b1, 64'h12, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 0, "wr_byte", rd, er);
        txn(1'b0, 64'h10, 2'd3, 64'd0, 0, "rd_part", rd, er);
        chk("rd_part.val", rd, 64'h1122334455AB7788);

        txn(1'b0, 64'h10, 2'd3, 64'd0, 5, "bp", rd, er);

        txn(1'b0, 64'(DEPTH - 4), 2'd3, 64'd0, 0, "rd_oob", rd, er);
        txn(1'b1, 64'h21, 2'd2, 64'hDEADBEEF, 0, "wr_mis", rd, er);
`ifdef DMEM_ERR_CHECK_EN
        chk("wr_mis.err", 64'(er), 64'd1);
`endif
        txn(1'b0, 64'h20, 2'd3, 64'd0, 0, "rd_after_mis", rd, er);
        txn(1'b0, 64'(DEPTH - 8), 2'd3, 64'd0, 0, "rd_top", rd, er);
        txn(1'b0, 64'(DEPTH - 1), 2'd0, 64'd0, 0, "rd_lastb", rd, er);
        txn(1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 2'd2, 64'd0, 0, "rd_wrap", rd, er);
        txn(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'h0102030405060708, 0, "wr_high", rd, er);

        txn(1'b1, 64'h40, 2'd3, 64'hCAFEF00D12345678, 0, "wr_prerst", rd, er);
        req_valid_i = 1'b1;
        req_we_i    = 1'b0;
        req_addr_i  = 64'h40;
        req_size_i  = 2'd3;
        @(negedge clk);
        req_valid_i = 1'b0;
        chk("midrst.wait", 64'(resp_valid_o), 64'd0);
        rst_n_i = 1'b0;
        #1;
        chk("midrst.vld",   64'(resp_valid_o), 64'd0);
        chk("midrst.rdy",   64'(req_ready_o),  64'd1);
        chk("midrst.rdata", resp_rdata_o,      64'd0);
        chk("midrst.err",   64'(resp_error_o), 64'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        @(negedge clk);
        txn(1'b0, 64'h40, 2'd3, 64'd0, 0, "rd_postrst", rd, er);
        chk("rd_postrst.val", rd, 64'hCAFEF00D12345678);

        repeat (200) begin
            case ($urandom_range(0, 3))
                0:       ra = 64'($urandom_range(0, DEPTH - 1));
                1:       ra = 64'($urandom_range(DEPTH - 8, DEPTH + 8));
                2:       ra = {$urandom, $urandom};
                default: ra = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            endcase
            txn(1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
                {$urandom, $urandom}, int'($urandom_range(0, 3)), "rand", rd, er);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
